mdu_hilo: RTL and testbench

- EX-stage multiply/divide unit, including the architectural HI/LO register pair.
- Runs MULT/MULTU (multi-cycle) and DIV/DIVU (iterative radix-2); executes MTHI/MTLO; supplies HI/LO for MFHI/MFLO.
- Drives div_mul_stall into the pipeline control unit, which freezes IF/ID/EX while the unit is busy.
- Results commit to HI/LO only when the instruction leaves EX, so flushes stay precise.

---
 rtl/mdu_pkg.sv | 62 ++++++
 rtl/div_radix2.sv | 71 +++++++
 rtl/mdu_hilo.sv | 170 +++++++++++++++++
 tb/tb_mdu_hilo.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// ============================================================================
// Package : mdu_pkg
// Brief   : Op encoding, FSM state encoding and decode helpers for mdu_hilo.
//           MDU_MADD_EN widens the op field and adds MADD/MADDU/MSUB/MSUBU.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package mdu_pkg;

`ifdef MDU_MADD_EN
    localparam int MDU_OP_W = 4;
`else
    localparam int MDU_OP_W = 3;
`endif

    localparam int DIV_ITERS = 32;

    localparam logic [MDU_OP_W-1:0] OP_NONE  = MDU_OP_W'(0);
    localparam logic [MDU_OP_W-1:0] OP_MULT  = MDU_OP_W'(1);
    localparam logic [MDU_OP_W-1:0] OP_MULTU = MDU_OP_W'(2);
    localparam logic [MDU_OP_W-1:0] OP_DIV   = MDU_OP_W'(3);
    localparam logic [MDU_OP_W-1:0] OP_DIVU  = MDU_OP_W'(4);
    localparam logic [MDU_OP_W-1:0] OP_MTHI  = MDU_OP_W'(5);
    localparam logic [MDU_OP_W-1:0] OP_MTLO  = MDU_OP_W'(6);
`ifdef MDU_MADD_EN
    localparam logic [MDU_OP_W-1:0] OP_MADD  = MDU_OP_W'(7);
    localparam logic [MDU_OP_W-1:0] OP_MADDU = MDU_OP_W'(8);
    localparam logic [MDU_OP_W-1:0] OP_MSUB  = MDU_OP_W'(9);
    localparam logic [MDU_OP_W-1:0] OP_MSUBU = MDU_OP_W'(10);
`endif

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    function automatic logic is_mul(input logic [MDU_OP_W-1:0] op);
        logic r;
        r = (op == OP_MULT) || (op == OP_MULTU);
`ifdef MDU_MADD_EN
        r = r || (op == OP_MADD) || (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
`endif
        return r;
    endfunction

    function automatic logic is_div(input logic [MDU_OP_W-1:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_signed_op(input logic [MDU_OP_W-1:0] op);
        logic r;
        r = (op == OP_MULT) || (op == OP_DIV);
`ifdef MDU_MADD_EN
        r = r || (op == OP_MADD) || (op == OP_MSUB);
`endif
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/div_radix2.sv
// ============================================================================
// Module : div_radix2
// Brief  : Iterative restoring divider on 32-bit magnitudes, one bit per
//          cycle. Outputs show the post-step values of the current cycle.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_radix2
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    logic [31:0] r_rem;
    logic [31:0] r_quo;
    logic [31:0] r_dvs;
    logic [5:0]  r_cnt;

    logic [32:0] w_shift;
    logic [32:0] w_diff;
    logic        w_ge;
    logic [31:0] w_rem_nxt;
    logic [31:0] w_quo_nxt;

    assign w_shift = {r_rem, r_quo[31]};
    assign w_diff  = w_shift - {1'b0, r_dvs};
    // A zero divisor always "fits", giving an all-ones quotient and rem = dividend.
    assign w_ge    = (r_dvs == 32'd0) || !w_diff[32];

    always_comb begin
        w_rem_nxt = w_shift[31:0];
        w_quo_nxt = {r_quo[30:0], 1'b0};
        if (w_ge) begin
            w_rem_nxt = w_diff[31:0];
            w_quo_nxt = {r_quo[30:0], 1'b1};
        end
    end

    assign done      = (r_cnt == 6'd1);
    assign quotient  = w_quo_nxt;
    assign remainder = w_rem_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem <= 32'd0;
            r_quo <= 32'd0;
            r_dvs <= 32'd0;
            r_cnt <= 6'd0;
        end else if (start) begin
            r_rem <= 32'd0;
            r_quo <= dividend;
            r_dvs <= divisor;
            r_cnt <= 6'(DIV_ITERS);
        end else if (r_cnt != 6'd0) begin
            r_rem <= w_rem_nxt;
            r_quo <= w_quo_nxt;
            r_cnt <= r_cnt - 6'd1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mdu_hilo.sv
// ============================================================================
// Module : mdu_hilo
// Brief  : EX-stage multiply/divide unit with architectural HI/LO; results
//          commit only when the instruction leaves EX. Optional MDU_MADD_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu_hilo
    import mdu_pkg::*;
#(
    parameter int MUL_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ex_valid,
    input  logic [MDU_OP_W-1:0] ex_op,
    input  logic [31:0]         ex_rs_data,
    input  logic [31:0]         ex_rt_data,
    input  logic                ex_hold,
    input  logic                flush,
    output logic                div_mul_stall,
    output logic [31:0]         hi,
    output logic [31:0]         lo
);

    localparam logic [4:0] c_mul_load = 5'(MUL_CYCLES - 1);
    localparam logic [4:0] c_div_load = 5'(DIV_ITERS - 1);

    logic [1:0]          r_state;
    logic [4:0]          r_cnt;
    logic [MDU_OP_W-1:0] r_op;
    logic [31:0]         r_a;
    logic [31:0]         r_b;
    logic [63:0]         r_result;
    logic [31:0]         r_hi;
    logic [31:0]         r_lo;

    logic        w_issue_op;
    logic        w_issue;
    logic        w_mt_en;
    logic        w_ex_signed;
    logic        w_start_div;
    logic [31:0] w_dvd_mag;
    logic [31:0] w_dvs_mag;
    logic        w_signed;
    logic        w_neg_a;
    logic        w_neg_b;
    logic [63:0] w_a_ext;
    logic [63:0] w_b_ext;
    logic [63:0] w_product;
    logic        w_div_done;
    logic [31:0] w_quo;
    logic [31:0] w_rem;
    logic [31:0] w_quo_fix;
    logic [31:0] w_rem_fix;
    logic [63:0] w_commit;

    assign w_issue_op  = ex_valid && (is_mul(ex_op) || is_div(ex_op));
    assign w_issue     = (r_state == ST_IDLE) && w_issue_op && !flush;
    assign w_mt_en     = (r_state == ST_IDLE) && ex_valid && !ex_hold && !flush;

    assign div_mul_stall = !flush && (((r_state == ST_IDLE) && w_issue_op) ||
                                      (r_state == ST_MUL) || (r_state == ST_DIV));

    // Divider sees magnitudes straight from the EX operands at issue.
    assign w_ex_signed = is_signed_op(ex_op);
    assign w_start_div = w_issue && is_div(ex_op);
    assign w_dvd_mag   = (w_ex_signed && ex_rs_data[31]) ? -ex_rs_data : ex_rs_data;
    assign w_dvs_mag   = (w_ex_signed && ex_rt_data[31]) ? -ex_rt_data : ex_rt_data;

    div_radix2 u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (w_start_div),
        .dividend  (w_dvd_mag),
        .divisor   (w_dvs_mag),
        .done      (w_div_done),
        .quotient  (w_quo),
        .remainder (w_rem)
    );

    assign w_signed  = is_signed_op(r_op);
    assign w_neg_a   = w_signed && r_a[31];
    assign w_neg_b   = w_signed && r_b[31];
    assign w_a_ext   = {{32{w_neg_a}}, r_a};
    assign w_b_ext   = {{32{w_neg_b}}, r_b};
    assign w_product = w_a_ext * w_b_ext;

    // Quotient negates on differing signs; remainder follows the dividend.
    assign w_quo_fix = (w_neg_a ^ w_neg_b) ? -w_quo : w_quo;
    assign w_rem_fix = w_neg_a ? -w_rem : w_rem;

    always_comb begin
        w_commit = r_result;
`ifdef MDU_MADD_EN
        if ((r_op == OP_MADD) || (r_op == OP_MADDU)) begin
            w_commit = {r_hi, r_lo} + r_result;
        end else if ((r_op == OP_MSUB) || (r_op == OP_MSUBU)) begin
            w_commit = {r_hi, r_lo} - r_result;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= 5'd0;
            r_op     <= OP_NONE;
            r_a      <= 32'd0;
            r_b      <= 32'd0;
            r_result <= 64'd0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_issue) begin
                        r_op    <= ex_op;
                        r_a     <= ex_rs_data;
                        r_b     <= ex_rt_data;
                        r_cnt   <= is_div(ex_op) ? c_div_load : c_mul_load;
                        r_state <= is_div(ex_op) ? ST_DIV : ST_MUL;
                    end else if (w_mt_en) begin
                        if (ex_op == OP_MTHI) r_hi <= ex_rs_data;
                        if (ex_op == OP_MTLO) r_lo <= ex_rs_data;
                    end
                end
                ST_MUL: begin
                    if (flush) begin
                        r_state <= ST_IDLE;
                    end else if (r_cnt == 5'd0) begin
                        r_result <= w_product;
                        r_state  <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt - 5'd1;
                    end
                end
                ST_DIV: begin
                    if (flush) begin
                        r_state <= ST_IDLE;
                    end else if (r_cnt == 5'd0) begin
                        if (w_div_done) begin
                            r_result <= {w_rem_fix, w_quo_fix};
                            r_state  <= ST_DONE;
                        end
                    end else begin
                        r_cnt <= r_cnt - 5'd1;
                    end
                end
                ST_DONE: begin
                    if (flush) begin
                        r_state <= ST_IDLE;
                    end else if (!ex_hold) begin
                        r_hi    <= w_commit[63:32];
                        r_lo    <= w_commit[31:0];
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign hi = r_hi;
    assign lo = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_mdu_hilo.sv
// ============================================================================
// Module : tb_mdu_hilo
// Brief  : Randomised self-checking bench for mdu_hilo against an arithmetic
//          HI/LO reference model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mdu_hilo;
    import mdu_pkg::*;

    localparam int MUL_CYCLES = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic                ex_valid;
    logic [MDU_OP_W-1:0] ex_op;
    logic [31:0]         ex_rs_data;
    logic [31:0]         ex_rt_data;
    logic                ex_hold;
    logic                flush;
    logic                div_mul_stall;
    logic [31:0]         hi;
    logic [31:0]         lo;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] hi_m;
    logic [31:0] lo_m;

    mdu_hilo #(.MUL_CYCLES(MUL_CYCLES)) dut (
        .clk           (clk),
        .rst           (rst),
        .ex_valid      (ex_valid),
        .ex_op         (ex_op),
        .ex_rs_data    (ex_rs_data),
        .ex_rt_data    (ex_rt_data),
        .ex_hold       (ex_hold),
        .flush         (flush),
        .div_mul_stall (div_mul_stall),
        .hi            (hi),
        .lo            (lo)
    );

    always #5 clk = ~clk;

    // {HI, LO} an instruction should produce, from the architectural rules.
    function automatic logic [63:0] ref_result(input logic [MDU_OP_W-1:0] op,
                                               input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ma, mb, q, r;
        logic   sg;
        sg = (op == OP_MULT) || (op == OP_DIV);
        sa = sg ? longint'($signed(a)) : longint'({32'b0, a});
        sb = sg ? longint'($signed(b)) : longint'({32'b0, b});
        if ((op == OP_MULT) || (op == OP_MULTU)) return 64'(sa * sb);
        ma = (sa < 0) ? -sa : sa;
        mb = (sb < 0) ? -sb : sb;
        q  = (mb == 0) ? 64'hFFFF_FFFF : ma / mb;
        r  = (mb == 0) ? ma : ma % mb;
        if ((sa < 0) != (sb < 0)) q = -q;
        if (sa < 0) r = -r;
        return {r[31:0], q[31:0]};
    endfunction

    // Entered and left 1 time unit after a rising edge.
    task automatic run_op(input logic [MDU_OP_W-1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input string name);
        int          n;
        int          exp_n;
        bit          fin;
        logic [63:0] exp;
        n     = 0;
        fin   = 0;
        exp   = ref_result(op, a, b);
        exp_n = ((op == OP_DIV) || (op == OP_DIVU)) ? 33 : 1 + MUL_CYCLES;
        ex_valid = 1'b1; ex_op = op; ex_rs_data = a; ex_rt_data = b;
        for (int i = 0; i < 100 && !fin; i++) begin
            @(negedge clk);
            if (!div_mul_stall) fin = 1;
            else begin n++; @(posedge clk); #1; end
        end
        @(posedge clk); #1;
        ex_valid = 1'b0; ex_op = OP_NONE;
        hi_m = exp[63:32]; lo_m = exp[31:0];
        checks++;
        if (n !== exp_n) begin
            errors++;
            $display("FAIL %s stall_cycles: got %0d expected %0d", name, n, exp_n);
        end
        checks++;
        if (hi !== hi_m || lo !== lo_m) begin
            errors++;
            $display("FAIL %s hilo: got %h_%h expected %h_%h (a=%h b=%h)",
                     name, hi, lo, hi_m, lo_m, a, b);
        end
    endtask

    task automatic do_mt(input logic [MDU_OP_W-1:0] op, input logic [31:0] v, input string name);
        ex_valid = 1'b1; ex_op = op; ex_rs_data = v;
        @(negedge clk);
        checks++;
        if (div_mul_stall !== 1'b0) begin
            errors++;
            $display("FAIL %s stall: got %b expected 0", name, div_mul_stall);
        end
        @(posedge clk); #1;
        ex_valid = 1'b0; ex_op = OP_NONE;
        if (op == OP_MTHI) hi_m = v; else lo_m = v;
        checks++;
        if (hi !== hi_m || lo !== lo_m) begin
            errors++;
            $display("FAIL %s hilo: got %h_%h expected %h_%h", name, hi, lo, hi_m, lo_m);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; ex_valid = 1'b0; ex_op = OP_NONE; ex_rs_data = '0; ex_rt_data = '0;
        ex_hold = 1'b0; flush = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        hi_m = 32'd0; lo_m = 32'd0;
        @(negedge clk);
        checks++;
        if (hi !== 32'd0 || lo !== 32'd0 || div_mul_stall !== 1'b0) begin
            errors++;
            $display("FAIL reset: got hi=%h lo=%h stall=%b expected 0 0 0", hi, lo, div_mul_stall);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_mult();
        run_op(OP_MULT, 32'hFFFF_FFFF, 32'h2, "mult_neg1x2");
        checks++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFE) begin
            errors++;
            $display("FAIL mult_vec: got %h_%h expected ffffffff_fffffffe", hi, lo);
        end
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'h2, "multu_vec");
        checks++;
        if (hi !== 32'h1 || lo !== 32'hFFFF_FFFE) begin
            errors++;
            $display("FAIL multu_vec: got %h_%h expected 00000001_fffffffe", hi, lo);
        end
        run_op(OP_MULT, 32'h8000_0000, 32'h8000_0000, "mult_minmin");
        repeat (8) run_op($urandom_range(0, 1) ? OP_MULT : OP_MULTU, $urandom, $urandom, "mult_rand");
    endtask

    task automatic test_div();
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'h2, "div_m7_2");
        checks++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
            errors++;
            $display("FAIL div_vec: got %h_%h expected ffffffff_fffffffd", hi, lo);
        end
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        checks++;
        if (hi !== 32'h0 || lo !== 32'h8000_0000) begin
            errors++;
            $display("FAIL div_ovf_vec: got %h_%h expected 00000000_80000000", hi, lo);
        end
        run_op(OP_DIVU, 32'h7, 32'h0, "divu_by0");
        checks++;
        if (hi !== 32'h7 || lo !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL divu_by0_vec: got %h_%h expected 00000007_ffffffff", hi, lo);
        end
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'h0, "div_by0_signed");
        repeat (8) begin
            logic [31:0] d;
            d = ($urandom_range(0, 3) == 0) ? 32'(($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 9))
                                            : $urandom;
            run_op($urandom_range(0, 1) ? OP_DIV : OP_DIVU, $urandom, d, "div_rand");
        end
    endtask

    task automatic test_mthi_mtlo();
        repeat (4) begin
            do_mt(OP_MTHI, $urandom, "mthi_rand");
            do_mt(OP_MTLO, $urandom, "mtlo_rand");
        end
    endtask

    task automatic test_flush();
        bit fin;
        do_mt(OP_MTHI, 32'h1234_5678, "flush_pre_hi");
        do_mt(OP_MTLO, 32'h1234_5678, "flush_pre_lo");
        ex_valid = 1'b1; ex_op = OP_DIV; ex_rs_data = $urandom; ex_rt_data = $urandom;
        repeat (9) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(negedge clk);
        checks++;
        if (div_mul_stall !== 1'b0 || hi !== hi_m || lo !== lo_m) begin
            errors++;
            $display("FAIL flush_busy: got stall=%b %h_%h expected 0 %h_%h", div_mul_stall, hi, lo, hi_m, lo_m);
        end
        @(posedge clk); #1;
        flush = 1'b0;
        do_mt(OP_MTHI, 32'hA5A5_A5A5, "flush_then_mthi");
        // Flush in DONE discards the pending product.
        fin = 0;
        ex_valid = 1'b1; ex_op = OP_MULT; ex_rs_data = 32'h3; ex_rt_data = 32'h5;
        for (int i = 0; i < 100 && !fin; i++) begin
            @(negedge clk);
            if (!div_mul_stall) fin = 1;
            else begin @(posedge clk); #1; end
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; ex_valid = 1'b0; ex_op = OP_NONE;
        checks++;
        if (!fin || hi !== hi_m || lo !== lo_m) begin
            errors++;
            $display("FAIL flush_done: got done=%b %h_%h expected 1 %h_%h", fin, hi, lo, hi_m, lo_m);
        end
    endtask

    task automatic test_hold();
        bit          fin;
        logic [31:0] a, b;
        logic [63:0] exp;
        fin = 0; a = $urandom; b = $urandom;
        exp = ref_result(OP_MULT, a, b);
        ex_hold = 1'b1;
        ex_valid = 1'b1; ex_op = OP_MULT; ex_rs_data = a; ex_rt_data = b;
        for (int i = 0; i < 100 && !fin; i++) begin
            @(negedge clk);
            if (!div_mul_stall) fin = 1;
            else begin @(posedge clk); #1; end
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (!fin || div_mul_stall !== 1'b0 || hi !== hi_m || lo !== lo_m) begin
                errors++;
                $display("FAIL hold_%0d: got done=%b stall=%b %h_%h expected 1 0 %h_%h",
                         k, fin, div_mul_stall, hi, lo, hi_m, lo_m);
            end
            @(posedge clk); #1;
            if (k < 2) @(negedge clk);
        end
        ex_hold = 1'b0;
        @(negedge clk);
        checks++;
        if (div_mul_stall !== 1'b0 || hi !== hi_m || lo !== lo_m) begin
            errors++;
            $display("FAIL hold_release: got stall=%b %h_%h expected 0 %h_%h", div_mul_stall, hi, lo, hi_m, lo_m);
        end
        @(posedge clk); #1;
        ex_valid = 1'b0; ex_op = OP_NONE;
        hi_m = exp[63:32]; lo_m = exp[31:0];
        checks++;
        if (hi !== hi_m || lo !== lo_m) begin
            errors++;
            $display("FAIL hold_commit: got %h_%h expected %h_%h", hi, lo, hi_m, lo_m);
        end
        do_mt(OP_MTLO, $urandom, "hold_idle_mtlo");
    endtask

    task automatic test_back_to_back();
        run_op(OP_MULT, $urandom, $urandom, "b2b_mult");
        run_op(OP_DIVU, $urandom, $urandom_range(1, 1000), "b2b_divu");
        do_mt(OP_MTLO, $urandom, "b2b_mtlo");
        run_op(OP_MULTU, $urandom, $urandom, "b2b_multu");
        run_op(OP_DIV, $urandom, $urandom, "b2b_div");
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_mthi_mtlo();
        test_flush();
        test_hold();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
